// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with valid/ready handshakes, bit-serial shifts and a shift-add multiply.
// Result and flags are registered and held in DONE until the consumer takes them.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       alu_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c,
   output logic             flag_v,
   output logic             out_illegal
);

   localparam logic [5:0] OP_OR   = 6'd0;
   localparam logic [5:0] OP_NAND = 6'd1;
   localparam logic [5:0] OP_NOR  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_ADD  = 6'd4;
   localparam logic [5:0] OP_SUB  = 6'd5;
   localparam logic [5:0] OP_XOR  = 6'd6;
   localparam logic [5:0] OP_SHL  = 6'd7;
   localparam logic [5:0] OP_SHR  = 6'd8;
   localparam logic [5:0] OP_ASR  = 6'd9;
   localparam logic [5:0] OP_MUL  = 6'd10;

   localparam logic [WIDTH-1:0] WMAX = WIDTH'(WIDTH);
   localparam logic [CNTW-1:0]  CMAX = CNTW'(WIDTH);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state, state_nx;
   logic                    accept, is_shift, multi, last, load;
   logic [5:0]              op_r;
   logic [2*WIDTH-1:0]      acc, step_acc;
   logic [WIDTH-1:0]        mcand, mul_add;
   logic [WIDTH:0]          mul_sum, add_w, sub_w;
   logic [CNTW-1:0]         cnt, k;
   logic                    step_c;
   logic signed [WIDTH-1:0] asr_in, asr_out;
   logic [WIDTH-1:0]        res;
   logic                    res_c, res_v, res_ill;

   function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
      return (sa != sb) && (sr != sa);
   endfunction

   assign in_ready = (state == IDLE) && !rst;
   assign accept   = in_valid && in_ready;
   assign is_shift = (alu_op == OP_SHL) || (alu_op == OP_SHR) || (alu_op == OP_ASR);
   assign multi    = (is_shift && (in_b != '0)) || (alu_op == OP_MUL);
   assign k        = (in_b >= WMAX) ? CMAX : in_b[CNTW-1:0];
   assign last     = (state == BUSY) && (cnt == CNTW'(1));
   assign load     = (accept && !multi) || last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = multi ? BUSY : DONE;
         BUSY:    if (cnt == CNTW'(1)) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == DONE);
   end

   // One iteration: a single-bit shift, or one shift-add step with the multiplier in acc's low half
   always_comb begin
      asr_in   = acc[WIDTH-1:0];
      asr_out  = asr_in >>> 1;
      mul_add  = acc[0] ? mcand : {WIDTH{1'b0}};
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
      step_acc = {mul_sum, acc[WIDTH-1:1]};
      step_c   = 1'b0;
      case (op_r)
         OP_SHL: begin
            step_acc = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], 1'b0};
            step_c   = acc[WIDTH-1];
         end
         OP_SHR: begin
            step_acc = {acc[2*WIDTH-1:WIDTH], 1'b0, acc[WIDTH-1:1]};
            step_c   = acc[0];
         end
         OP_ASR: begin
            step_acc = {acc[2*WIDTH-1:WIDTH], asr_out};
            step_c   = acc[0];
         end
         default: ;
      endcase
   end

   always_comb begin
      add_w   = {1'b0, in_a} + {1'b0, in_b};
      sub_w   = {1'b0, in_a} - {1'b0, in_b};
      res     = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_ill = 1'b0;
      if (state == BUSY) begin
         res = step_acc[WIDTH-1:0];
         if (op_r == OP_MUL) res_v = |step_acc[2*WIDTH-1:WIDTH];
         else                res_c = step_c;
      end else begin
         case (alu_op)
            OP_OR:   res = in_a | in_b;
            OP_NAND: res = ~(in_a & in_b);
            OP_NOR:  res = ~(in_a | in_b);
            OP_AND:  res = in_a & in_b;
            OP_XOR:  res = in_a ^ in_b;
            OP_ADD: begin
               res   = add_w[WIDTH-1:0];
               res_c = add_w[WIDTH];
               res_v = add_ovf(in_a[WIDTH-1], in_b[WIDTH-1], add_w[WIDTH-1]);
            end
            OP_SUB: begin
               res   = sub_w[WIDTH-1:0];
               res_c = sub_w[WIDTH];
               res_v = sub_ovf(in_a[WIDTH-1], in_b[WIDTH-1], sub_w[WIDTH-1]);
            end
            OP_SHL, OP_SHR, OP_ASR: res = in_a;
            OP_MUL: ;
            default: res_ill = 1'b1;
         endcase
      end
   end

   // Operand/iteration state carries no reset: it is reloaded on every accept
   always_ff @(posedge clk) begin
      if (accept) begin
         op_r  <= alu_op;
         acc   <= {{WIDTH{1'b0}}, in_a};
         mcand <= in_b;
         cnt   <= (alu_op == OP_MUL) ? CMAX : k;
      end else if (state == BUSY) begin
         acc <= step_acc;
         cnt <= cnt - CNTW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out         <= '0;
         flag_z      <= 1'b0;
         flag_n      <= 1'b0;
         flag_c      <= 1'b0;
         flag_v      <= 1'b0;
         out_illegal <= 1'b0;
      end else if (load) begin
         out         <= res;
         flag_z      <= (res == '0);
         flag_n      <= res[WIDTH-1];
         flag_c      <= res_c;
         flag_v      <= res_v;
         out_illegal <= res_ill;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: an 8-bit and a 16-bit instance, directed vectors with
// hand-computed results, flags and latencies.
module tb_alu_seq;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  fl;   // {z, n, c, v, illegal}
      int          cyc;
   } exp_t;

   logic        clk, rst;
   logic        iv8, rdy8, ov8, ordy8, z8, n8, c8, v8, ill8;
   logic [5:0]  op8;
   logic [7:0]  a8, b8, out8;
   logic        iv16, rdy16, ov16, ordy16, z16, n16, c16, v16, ill16;
   logic [5:0]  op16;
   logic [15:0] a16, b16, out16;

   int   cyc = 0;
   int   nvec = 0;
   int   nfail = 0;
   bit   seen8 = 0;
   bit   seen16 = 0;
   exp_t sb8[$];
   exp_t sb16[$];

   alu_seq #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .alu_op(op8),
      .in_a(a8), .in_b(b8), .out_valid(ov8), .out_ready(ordy8), .out(out8),
      .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8), .out_illegal(ill8)
   );

   alu_seq #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(rdy16), .alu_op(op16),
      .in_a(a16), .in_b(b16), .out_valid(ov16), .out_ready(ordy16), .out(out16),
      .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16), .out_illegal(ill16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      nvec++;
      nfail++;
      $display("FAIL %s: bound expired or unexpected event at cycle %0d", name, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst && ov8) begin
         if (sb8.size() == 0) fail_now("w8 unexpected output");
         else begin
            chk("w8 result/flags", {32'(out8), z8, n8, c8, v8, ill8}, {sb8[0].res, sb8[0].fl});
            if (!seen8) chk("w8 latency", 64'(cyc), 64'(sb8[0].cyc));
            seen8 = 1;
            if (ordy8) begin
               void'(sb8.pop_front());
               seen8 = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && ov16) begin
         if (sb16.size() == 0) fail_now("w16 unexpected output");
         else begin
            chk("w16 result/flags", {32'(out16), z16, n16, c16, v16, ill16}, {sb16[0].res, sb16[0].fl});
            if (!seen16) chk("w16 latency", 64'(cyc), 64'(sb16[0].cyc));
            seen16 = 1;
            if (ordy16) begin
               void'(sb16.pop_front());
               seen16 = 0;
            end
         end
      end
   end

   task automatic issue(input bit w16, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input logic [4:0] fl, input int lat);
      int   t;
      exp_t e;
      @(negedge clk);
      if (w16) begin op16 = op; a16 = a[15:0]; b16 = b[15:0]; iv16 = 1'b1; end
      else     begin op8 = op;  a8 = a[7:0];   b8 = b[7:0];   iv8 = 1'b1;  end
      t = 0;
      while (!(w16 ? rdy16 : rdy8) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) fail_now("issue wait for in_ready");
      else begin
         e.res = r;
         e.fl  = fl;
         e.cyc = cyc + lat;
         if (w16) sb16.push_back(e);
         else     sb8.push_back(e);
      end
      @(posedge clk);
      #1;
      iv8  = 1'b0;
      iv16 = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while ((sb8.size() != 0 || sb16.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) fail_now("drain scoreboard");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rst = 1'b0; iv8 = 1'b0; iv16 = 1'b0; ordy8 = 1'b1; ordy16 = 1'b1;
      op8 = '0; a8 = '0; b8 = '0; op16 = '0; a16 = '0; b16 = '0;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset out8", 64'(out8), 64'h0);
      chk("reset flags8", {z8, n8, c8, v8, ill8}, 64'h0);
      chk("reset out_valid8", 64'(ov8), 64'h0);
      chk("reset in_ready8", 64'(rdy8), 64'h0);
      chk("reset out16", 64'(out16), 64'h0);
      chk("reset in_ready16", 64'(rdy16), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("release in_ready8", 64'(rdy8), 64'h1);

      issue(0, 6'h04, 'h7F, 'h01, 'h80, 5'b01010, 1);
      issue(0, 6'h05, 'h00, 'h01, 'hFF, 5'b01100, 1);
      issue(0, 6'h03, 'hF0, 'h0F, 'h00, 5'b10000, 1);
      issue(0, 6'h07, 'h81, 'h03, 'h08, 5'b00000, 4);
      issue(0, 6'h09, 'h80, 'h09, 'hFF, 5'b01100, 9);
      issue(0, 6'h08, 'h80, 'h00, 'h80, 5'b01000, 1);
      issue(0, 6'h0A, 'h10, 'h11, 'h10, 5'b00010, 9);
      issue(0, 6'h0A, 'h0F, 'h0F, 'hE1, 5'b01000, 9);
      issue(0, 6'h3F, 'h12, 'h34, 'h00, 5'b10001, 1);
      issue(0, 6'h00, 'hA0, 'h05, 'hA5, 5'b01000, 1);
      issue(0, 6'h01, 'hFF, 'hFF, 'h00, 5'b10000, 1);
      issue(0, 6'h02, 'h0F, 'h30, 'hC0, 5'b01000, 1);
      issue(0, 6'h06, 'hAA, 'hFF, 'h55, 5'b00000, 1);
      issue(0, 6'h05, 'h80, 'h01, 'h7F, 5'b00010, 1);
      issue(0, 6'h08, 'h81, 'h01, 'h40, 5'b00100, 2);
      issue(0, 6'h07, 'hFF, 'h08, 'h00, 5'b10100, 9);
      issue(0, 6'h04, 'hFF, 'h01, 'h00, 5'b10100, 1);
      issue(0, 6'h08, 'hFF, 'hC8, 'h00, 5'b10100, 9);
      issue(0, 6'h09, 'h70, 'h02, 'h1C, 5'b00000, 3);
      issue(1, 6'h04, 'hFFFF, 'h0001, 'h0000, 5'b10100, 1);
      issue(1, 6'h07, 'h8001, 'h0010, 'h0000, 5'b10100, 17);
      issue(1, 6'h0A, 'h0100, 'h0100, 'h0000, 5'b10010, 17);
      drain();

      // Backpressure: result held in DONE while new requests are refused
      ordy8 = 1'b0;
      issue(0, 6'h04, 'h12, 'h34, 'h46, 5'b00000, 1);
      t = 0;
      while (!ov8 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) fail_now("stall wait for out_valid");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         op8 = 6'h05; a8 = 8'h99; b8 = 8'h11; iv8 = 1'b1;
         #1 chk("stall in_ready8", 64'(rdy8), 64'h0);
      end
      @(negedge clk);
      iv8 = 1'b0;
      @(posedge clk);
      #1 ordy8 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("after take in_ready8", 64'(rdy8), 64'h1);
      chk("after take out_valid8", 64'(ov8), 64'h0);

      // Reset during a multiply aborts it; no result is expected
      issue(0, 6'h0A, 'h03, 'h05, 'h0F, 5'b00000, 9);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      sb8.delete();
      seen8 = 0;
      #1;
      chk("mid-mul reset out_valid8", 64'(ov8), 64'h0);
      chk("mid-mul reset out8", 64'(out8), 64'h0);
      chk("mid-mul reset in_ready8", 64'(rdy8), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("post-reset in_ready8", 64'(rdy8), 64'h1);
      issue(0, 6'h04, 'h01, 'h02, 'h03, 5'b00000, 1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
